// File: rtl/inst_fetcher.sv
// Front-end fetch unit: owns the PC, looks up the Icache, refills from the memory controller on a miss
// and delivers one instruction per cycle to the decoder. Define IF_STATIC_PREDICT_EN for static JAL/backward-branch prediction.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] if_to_ic_inst_addr,
  output logic [31:0] if_to_ic_inst,
  output logic        if_to_ic_inst_valid,
  input  logic        ic_to_if_hit,
  input  logic [31:0] ic_to_if_hit_inst,
  output logic        if_to_mc_req,
  output logic [31:0] if_to_mc_addr,
  input  logic        mc_to_if_done,
  input  logic [31:0] mc_to_if_inst,
  input  logic        dec_stall_in,
  output logic        if_to_dec_valid,
  output logic [31:0] if_to_dec_inst,
  output logic [31:0] if_to_dec_pc,
  output logic        if_to_dec_pred_jump,
  input  logic        rob_flush_in,
  input  logic [31:0] rob_new_pc
);

  typedef enum logic {
    S_FETCH,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] miss_addr_q, miss_addr_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic        req_q, req_d;
  logic        dec_valid_q, dec_valid_d;
  logic [31:0] dec_inst_q, dec_inst_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  logic        pred_q, pred_d;

  logic [31:0] next_pc;
  logic        pred_taken;

`ifdef IF_STATIC_PREDICT_EN
  logic [6:0]  opcode;
  logic [31:0] j_imm;
  logic [31:0] b_imm;

  always_comb begin
    opcode     = ic_to_if_hit_inst[6:0];
    j_imm      = {{11{ic_to_if_hit_inst[31]}}, ic_to_if_hit_inst[31], ic_to_if_hit_inst[19:12],
                  ic_to_if_hit_inst[20], ic_to_if_hit_inst[30:21], 1'b0};
    b_imm      = {{19{ic_to_if_hit_inst[31]}}, ic_to_if_hit_inst[31], ic_to_if_hit_inst[7],
                  ic_to_if_hit_inst[30:25], ic_to_if_hit_inst[11:8], 1'b0};
    next_pc    = pc_q + 32'd4;
    pred_taken = 1'b0;
    if (opcode == 7'b1101111) begin
      next_pc    = pc_q + j_imm;
      pred_taken = 1'b1;
    end else if (opcode == 7'b1100011 && ic_to_if_hit_inst[31]) begin
      // only backward branches are predicted taken
      next_pc    = pc_q + b_imm;
      pred_taken = 1'b1;
    end
  end
`else
  assign next_pc    = pc_q + 32'd4;
  assign pred_taken = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    mc_addr_d   = mc_addr_q;
    req_d       = req_q;
    dec_valid_d = dec_valid_q;
    dec_inst_d  = dec_inst_q;
    dec_pc_d    = dec_pc_q;
    pred_d      = pred_q;
    // rdy_in low freezes everything, including a valid pulse already on the decoder port
    if (rdy_in) begin
      dec_valid_d = 1'b0;
      unique case (state_q)
        S_FETCH: begin
          if (rob_flush_in) begin
            pc_d = rob_new_pc;
          end else if (!dec_stall_in) begin
            if (ic_to_if_hit) begin
              dec_valid_d = 1'b1;
              dec_inst_d  = ic_to_if_hit_inst;
              dec_pc_d    = pc_q;
              pred_d      = pred_taken;
              pc_d        = next_pc;
            end else begin
              miss_addr_d = pc_q;
              mc_addr_d   = pc_q;
              req_d       = 1'b1;
              state_d     = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // a redirect does not cancel the refill; the line is still valid for miss_addr
          if (rob_flush_in) begin
            pc_d = rob_new_pc;
          end
          if (mc_to_if_done) begin
            req_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      miss_addr_q <= '0;
      mc_addr_q   <= '0;
      req_q       <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_inst_q  <= '0;
      dec_pc_q    <= '0;
      pred_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      mc_addr_q   <= mc_addr_d;
      req_q       <= req_d;
      dec_valid_q <= dec_valid_d;
      dec_inst_q  <= dec_inst_d;
      dec_pc_q    <= dec_pc_d;
      pred_q      <= pred_d;
    end
  end

  assign if_to_ic_inst_addr  = (state_q == S_WAIT) ? miss_addr_q : pc_q;
  assign if_to_ic_inst       = mc_to_if_inst;
  assign if_to_ic_inst_valid = (state_q == S_WAIT) && mc_to_if_done && rdy_in;
  assign if_to_mc_req        = req_q;
  assign if_to_mc_addr       = mc_addr_q;
  assign if_to_dec_valid     = dec_valid_q;
  assign if_to_dec_inst      = dec_inst_q;
  assign if_to_dec_pc        = dec_pc_q;
  assign if_to_dec_pred_jump = pred_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: Icache and memory-controller models plus an in-order fetch-stream model
// checked every cycle, and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_inst_fetcher;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [31:0] if_to_ic_inst_addr, if_to_ic_inst;
  logic        if_to_ic_inst_valid;
  logic        ic_to_if_hit;
  logic [31:0] ic_to_if_hit_inst;
  logic        if_to_mc_req;
  logic [31:0] if_to_mc_addr;
  logic        mc_to_if_done = 1'b0;
  logic [31:0] mc_to_if_inst = 32'h0;
  logic        dec_stall_in;
  logic        if_to_dec_valid;
  logic [31:0] if_to_dec_inst, if_to_dec_pc;
  logic        if_to_dec_pred_jump;
  logic        rob_flush_in;
  logic [31:0] rob_new_pc;

  inst_fetcher #(.RESET_PC(RESET_PC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_to_ic_inst_addr(if_to_ic_inst_addr), .if_to_ic_inst(if_to_ic_inst),
    .if_to_ic_inst_valid(if_to_ic_inst_valid),
    .ic_to_if_hit(ic_to_if_hit), .ic_to_if_hit_inst(ic_to_if_hit_inst),
    .if_to_mc_req(if_to_mc_req), .if_to_mc_addr(if_to_mc_addr),
    .mc_to_if_done(mc_to_if_done), .mc_to_if_inst(mc_to_if_inst),
    .dec_stall_in(dec_stall_in),
    .if_to_dec_valid(if_to_dec_valid), .if_to_dec_inst(if_to_dec_inst),
    .if_to_dec_pc(if_to_dec_pc), .if_to_dec_pred_jump(if_to_dec_pred_jump),
    .rob_flush_in(rob_flush_in), .rob_new_pc(rob_new_pc)
  );

  always #5 clk_in = ~clk_in;

  // Backing memory image: every address has a fixed word, two of them pinned for the scenarios.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)  return 32'h0010_0093;
    if (a == 32'h20) return 32'h0100_006F;  // jal x0, +16
    return a ^ 32'h5A5A_0013;
  endfunction

  // Architectural next fetch address after delivering inst at pc: {predicted, next_pc}.
  function automatic logic [32:0] model_next(input logic [31:0] pc, input logic [31:0] inst);
`ifdef IF_STATIC_PREDICT_EN
    logic [31:0] j, b;
    j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    if (inst[6:0] == 7'b1101111) return {1'b1, pc + j};
    if (inst[6:0] == 7'b1100011 && inst[31]) return {1'b1, pc + b};
`endif
    return {1'b0, pc + 32'd4};
  endfunction

  // Icache model: preloaded lines plus lines filled during the current test (epoch).
  logic        pre_v   [64];
  logic [31:0] pre_tag [64];
  int unsigned fill_ep [64];
  logic [31:0] fill_tag[64];
  int unsigned epoch = 1;
  logic [5:0]  ic_idx;
  assign ic_idx = if_to_ic_inst_addr[7:2];
  always_comb begin
    ic_to_if_hit      = (pre_v[ic_idx] && pre_tag[ic_idx] == if_to_ic_inst_addr) ||
                        (fill_ep[ic_idx] == epoch && fill_tag[ic_idx] == if_to_ic_inst_addr);
    ic_to_if_hit_inst = mem_word(if_to_ic_inst_addr);
  end

  // Memory controller model: done pulses after mc_lat cycles of request.
  int unsigned mc_lat = 4;
  int unsigned mc_cnt = 0;
  always @(posedge clk_in) begin
    #1;
    if (mc_to_if_done) begin
      mc_to_if_done = 1'b0;
      mc_cnt = 0;
    end else if (if_to_mc_req) begin
      mc_cnt++;
      if (mc_cnt >= mc_lat) begin
        mc_to_if_done = 1'b1;
        mc_to_if_inst = mem_word(if_to_mc_addr);
      end
    end else begin
      mc_cnt = 0;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] req_addr = 32'h0;
  logic        req_prev = 1'b0;
  int          req_run = 0;
  logic [31:0] del_pc[$], del_inst[$], fill_addr[$];
  logic        del_pred[$];
  int          del_cyc[$], fill_cyc[$], req_len[$];
  int          d0, f0, r0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dpc(int k);
    return (d0 + k < del_pc.size()) ? del_pc[d0 + k] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] dins(int k);
    return (d0 + k < del_inst.size()) ? del_inst[d0 + k] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic dprd(int k);
    return (d0 + k < del_pred.size()) ? del_pred[d0 + k] : 1'bx;
  endfunction
  function automatic int dcy(int k);
    return (d0 + k < del_cyc.size()) ? del_cyc[d0 + k] : -1000;
  endfunction
  function automatic logic [31:0] fad(int k);
    return (f0 + k < fill_addr.size()) ? fill_addr[f0 + k] : 32'hDEAD_BEEF;
  endfunction
  function automatic int fcy(int k);
    return (f0 + k < fill_cyc.size()) ? fill_cyc[f0 + k] : -1000;
  endfunction
  function automatic int rln(int k);
    return (r0 + k < req_len.size()) ? req_len[r0 + k] : -1;
  endfunction

  // One clock: check the combinational fill port against the inputs about to be sampled,
  // let the edge happen, then check the registered outputs against the fetch-stream model.
  task automatic tick();
    logic        c_rst, c_rdy, c_fl;
    logic [31:0] c_npc;
    logic [32:0] nx;
    #1;
    c_rst = rst_in; c_rdy = rdy_in; c_fl = rob_flush_in; c_npc = rob_new_pc;
    if (!c_rst) begin
      if (mc_to_if_done && c_rdy) begin
        chk("fill_strobe", 32'(if_to_ic_inst_valid), 32'd1);
        chk("fill_addr", if_to_ic_inst_addr, req_addr);
        chk("fill_data", if_to_ic_inst, mem_word(if_to_ic_inst_addr));
        fill_addr.push_back(if_to_ic_inst_addr);
        fill_cyc.push_back(cyc);
        fill_ep[if_to_ic_inst_addr[7:2]]  = epoch;
        fill_tag[if_to_ic_inst_addr[7:2]] = if_to_ic_inst_addr;
      end else begin
        chk("fill_idle", 32'(if_to_ic_inst_valid), 32'd0);
      end
    end
    @(negedge clk_in);
    #2;
    cyc++;
    if (c_rst) begin
      exp_pc = RESET_PC;
      req_prev = 1'b0;
      req_run = 0;
      chk("rst_valid", 32'(if_to_dec_valid), 32'd0);
      chk("rst_req", 32'(if_to_mc_req), 32'd0);
    end else begin
      if (c_rdy) begin
        if (c_fl) begin
          chk("flush_no_deliver", 32'(if_to_dec_valid), 32'd0);
          exp_pc = c_npc;
        end else if (if_to_dec_valid) begin
          nx = model_next(exp_pc, mem_word(exp_pc));
          chk("dec_pc", if_to_dec_pc, exp_pc);
          chk("dec_inst", if_to_dec_inst, mem_word(exp_pc));
          chk("dec_pred", 32'(if_to_dec_pred_jump), 32'(nx[32]));
          del_pc.push_back(if_to_dec_pc);
          del_inst.push_back(if_to_dec_inst);
          del_pred.push_back(if_to_dec_pred_jump);
          del_cyc.push_back(cyc);
          exp_pc = nx[31:0];
        end
      end
      if (if_to_mc_req) begin
        if (!req_prev) req_addr = exp_pc;
        chk("req_addr", if_to_mc_addr, req_addr);
        req_run++;
      end else if (req_prev) begin
        req_len.push_back(req_run);
        req_run = 0;
      end
      req_prev = if_to_mc_req;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic preload(input logic [31:0] a);
    pre_v[a[7:2]]   = 1'b1;
    pre_tag[a[7:2]] = a;
  endtask

  // Holds reset two cycles with an empty cache, pins the reset state, marks log starting points.
  task automatic begin_test(input int unsigned lat);
    rst_in = 1'b1; rdy_in = 1'b1; rob_flush_in = 1'b0; rob_new_pc = 32'h0; dec_stall_in = 1'b0;
    mc_lat = lat;
    epoch++;
    for (int i = 0; i < 64; i++) pre_v[i] = 1'b0;
    run(2);
    chk("rst_mc_addr", if_to_mc_addr, 32'h0);
    chk("rst_dec_pc", if_to_dec_pc, 32'h0);
    chk("rst_dec_inst", if_to_dec_inst, 32'h0);
    chk("rst_pred", 32'(if_to_dec_pred_jump), 32'd0);
    chk("rst_ic_addr", if_to_ic_inst_addr, RESET_PC);
    d0 = del_pc.size(); f0 = fill_addr.size(); r0 = req_len.size();
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 64; i++) begin
      pre_v[i] = 1'b0; pre_tag[i] = 32'h0; fill_ep[i] = 0; fill_tag[i] = 32'h0;
    end

    // Back-to-back hits
    begin_test(4);
    preload(32'h0); preload(32'h4); preload(32'h8);
    rst_in = 1'b0;
    t0 = cyc;
    run(8);
    chk("t1_pc0", dpc(0), 32'h0);
    chk("t1_pc1", dpc(1), 32'h4);
    chk("t1_pc2", dpc(2), 32'h8);
    chk("t1_lat", 32'(dcy(0) - t0), 32'd1);
    chk("t1_gap1", 32'(dcy(1) - dcy(0)), 32'd1);
    chk("t1_gap2", 32'(dcy(2) - dcy(1)), 32'd1);

    // Cold miss with a 4-cycle memory controller
    begin_test(4);
    rst_in = 1'b0;
    run(12);
    chk("t2_req_len", 32'(rln(0)), 32'd4);
    chk("t2_fill_addr", fad(0), 32'h0);
    chk("t2_pc", dpc(0), 32'h0);
    chk("t2_inst", dins(0), 32'h0010_0093);
    chk("t2_fill_to_dec", 32'(dcy(0) - fcy(0)), 32'd2);

    // Redirect during a refill
    begin_test(4);
    preload(32'h100); preload(32'h104);
    rst_in = 1'b0;
    run(2);
    rob_flush_in = 1'b1; rob_new_pc = 32'h100;
    tick();
    rob_flush_in = 1'b0;
    run(12);
    chk("t3_fill_addr", fad(0), 32'h0);
    chk("t3_req_len", 32'(rln(0)), 32'd4);
    chk("t3_pc0", dpc(0), 32'h100);
    chk("t3_pc1", dpc(1), 32'h104);

    // Decoder stall for three cycles during hits
    begin_test(4);
    for (int a = 0; a < 32; a += 4) preload(32'(a));
    rst_in = 1'b0;
    run(2);
    dec_stall_in = 1'b1;
    tick();
    chk("t4_stall_pc", if_to_ic_inst_addr, 32'h8);
    chk("t4_stall_valid", 32'(if_to_dec_valid), 32'd0);
    run(2);
    dec_stall_in = 1'b0;
    run(6);
    chk("t4_pc1", dpc(1), 32'h4);
    chk("t4_pc2", dpc(2), 32'h8);
    chk("t4_pc3", dpc(3), 32'hC);
    chk("t4_gap", 32'(dcy(2) - dcy(1)), 32'd4);

    // rdy_in low for five cycles in the middle of a refill
    begin_test(12);
    rst_in = 1'b0;
    run(3);
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_frozen_req", 32'(if_to_mc_req), 32'd1);
      chk("t5_frozen_addr", if_to_mc_addr, 32'h0);
      chk("t5_frozen_ic_addr", if_to_ic_inst_addr, 32'h0);
    end
    rdy_in = 1'b1;
    run(16);
    chk("t5_req_len", 32'(rln(0)), 32'd12);
    chk("t5_fill_addr", fad(0), 32'h0);
    chk("t5_pc", dpc(0), 32'h0);
    chk("t5_inst", dins(0), 32'h0010_0093);

    // PC wraps past the top of the address space
    begin_test(4);
    preload(32'hFFFF_FFF8); preload(32'hFFFF_FFFC); preload(32'h0);
    rst_in = 1'b0; rob_flush_in = 1'b1; rob_new_pc = 32'hFFFF_FFF8;
    tick();
    rob_flush_in = 1'b0;
    run(5);
    chk("tw_pc0", dpc(0), 32'hFFFF_FFF8);
    chk("tw_pc1", dpc(1), 32'hFFFF_FFFC);
    chk("tw_pc2", dpc(2), 32'h0);

    // JAL +16 at 0x20
    begin_test(4);
    preload(32'h20); preload(32'h24); preload(32'h30);
    rst_in = 1'b0; rob_flush_in = 1'b1; rob_new_pc = 32'h20;
    tick();
    rob_flush_in = 1'b0;
    run(4);
    chk("t6_pc0", dpc(0), 32'h20);
    chk("t6_inst0", dins(0), 32'h0100_006F);
`ifdef IF_STATIC_PREDICT_EN
    chk("t6_pred", 32'(dprd(0)), 32'd1);
    chk("t6_pc1", dpc(1), 32'h30);
`else
    chk("t6_pred", 32'(dprd(0)), 32'd0);
    chk("t6_pc1", dpc(1), 32'h24);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
